// File: rtl/polling_rx_substate.sv
// ---------------------------------------------------------------------------
// polling_rx_substate
//
// Rx-side Polling controller. While mainLTSSM sits in pollingActive (2) or
// pollingConfiguration (3) it counts consecutive qualifying training sets,
// runs the Polling timeout, and requests the next substate through
// finishRx/gotoRx: pollingConfiguration (3), configurationLinkWidthStart (4)
// or detectQuiet (0, on timeout).
//
// Ports
//   clk        in   1  core clock
//   reset      in   1  asynchronous, active-low reset
//   substateRx in   4  current Rx substate from mainLTSSM
//   osValid    in   1  one decoded ordered set presented this cycle
//   osType     in   2  00=other, 01=TS1, 10=TS2, 11=reserved (treated as other)
//   osLinkNum  in   8  link number field of the TS
//   osLaneNum  in   8  lane number field of the TS
//   finishRx   out  1  level; request to leave the current substate
//   gotoRx     out  4  requested next substate, valid while finishRx=1
//   tsCount    out  4  current consecutive-TS count
//   timeoutHit out  1  one-cycle pulse when a Polling timeout fires
//
// Configuration
//   POLLING_RX_PAD_CHECK_EN  when defined, a TS qualifies only if both its
//                            link and lane numbers are PAD (8'hF7); otherwise
//                            it counts as "other OS". When undefined the
//                            link/lane fields are ignored.
// ---------------------------------------------------------------------------
module polling_rx_substate #(
  parameter int TS_COUNT       = 8,
  parameter int TIMEOUT_ACTIVE = 24000,
  parameter int TIMEOUT_CONFIG = 48000,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] substateRx,
  input  logic       osValid,
  input  logic [1:0] osType,
  input  logic [7:0] osLinkNum,
  input  logic [7:0] osLaneNum,
  output logic       finishRx,
  output logic [3:0] gotoRx,
  output logic [3:0] tsCount,
  output logic       timeoutHit
);

  // Controller states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_CONFIG = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // mainLTSSM substate encodings
  localparam logic [3:0] SUB_DETECT_QUIET = 4'd0;
  localparam logic [3:0] SUB_POLL_ACTIVE  = 4'd2;
  localparam logic [3:0] SUB_POLL_CONFIG  = 4'd3;
  localparam logic [3:0] SUB_CFG_LWSTART  = 4'd4;

  localparam logic [1:0] OS_TS1 = 2'b01;
  localparam logic [1:0] OS_TS2 = 2'b10;
  localparam logic [7:0] PAD    = 8'hF7;

  localparam logic [3:0]       TS_TARGET  = 4'(TS_COUNT);
  localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(TIMEOUT_ACTIVE - 1);
  localparam logic [CNT_W-1:0] CFG_LAST   = CNT_W'(TIMEOUT_CONFIG - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX  = '1;

  logic [1:0]       state;
  logic [3:0]       ts_count;
  logic [CNT_W-1:0] timer;
  logic [3:0]       goto_reg;
  logic             finish_reg;
  logic             timeout_reg;
  logic [3:0]       entry_sub;   // substateRx seen when DONE was entered

  logic       pad_ok;
  logic       qual_ts;
  logic [3:0] count_next;
  logic       ts_reached;
  logic       timer_last;
  logic       in_polling;
  logic [3:0] state_sub;         // substate the current counting state tracks

`ifdef POLLING_RX_PAD_CHECK_EN
  assign pad_ok = (osLinkNum == PAD) && (osLaneNum == PAD);
`else
  assign pad_ok = 1'b1;
  logic unused_fields;
  assign unused_fields = ^{osLinkNum, osLaneNum};
`endif

  assign in_polling = (substateRx == SUB_POLL_ACTIVE) || (substateRx == SUB_POLL_CONFIG);
  assign state_sub  = (state == ST_CONFIG) ? SUB_POLL_CONFIG : SUB_POLL_ACTIVE;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    qual_ts    = 1'b0;
    count_next = ts_count;
    timer_last = 1'b0;
    if (state == ST_CONFIG) begin
      qual_ts    = (osType == OS_TS2) && pad_ok;
      timer_last = (timer == CFG_LAST);
    end else begin
      qual_ts    = ((osType == OS_TS1) || (osType == OS_TS2)) && pad_ok;
      timer_last = (timer == ACT_LAST);
    end
    // Cycles without an ordered set neither advance nor clear the run.
    if (osValid) begin
      if (!qual_ts)                   count_next = 4'd0;
      else if (ts_count != TS_TARGET) count_next = ts_count + 4'd1;
    end
  end

  assign ts_reached = (count_next == TS_TARGET);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      ts_count    <= 4'd0;
      timer       <= '0;
      goto_reg    <= SUB_DETECT_QUIET;
      finish_reg  <= 1'b0;
      timeout_reg <= 1'b0;
      entry_sub   <= 4'd0;
    end else begin
      timeout_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          finish_reg <= 1'b0;
          goto_reg   <= SUB_DETECT_QUIET;
          ts_count   <= 4'd0;
          timer      <= '0;
          if (substateRx == SUB_POLL_ACTIVE)      state <= ST_ACTIVE;
          else if (substateRx == SUB_POLL_CONFIG) state <= ST_CONFIG;
        end

        ST_ACTIVE, ST_CONFIG: begin
          if (!in_polling) begin
            // mainLTSSM left Polling on its own: drop out quietly.
            state    <= ST_IDLE;
            ts_count <= 4'd0;
            timer    <= '0;
          end else if (substateRx != state_sub) begin
            // Direct hop between the two Polling substates restarts counting.
            state    <= (substateRx == SUB_POLL_CONFIG) ? ST_CONFIG : ST_ACTIVE;
            ts_count <= 4'd0;
            timer    <= '0;
          end else begin
            ts_count <= count_next;
            if (timer != TIMER_MAX) timer <= timer + 1'b1;
            // Success is checked first so it wins over a simultaneous timeout.
            if (ts_reached) begin
              state      <= ST_DONE;
              finish_reg <= 1'b1;
              goto_reg   <= (state == ST_CONFIG) ? SUB_CFG_LWSTART : SUB_POLL_CONFIG;
              entry_sub  <= substateRx;
            end else if (timer_last) begin
              state       <= ST_DONE;
              finish_reg  <= 1'b1;
              goto_reg    <= SUB_DETECT_QUIET;
              timeout_reg <= 1'b1;
              entry_sub   <= substateRx;
            end
          end
        end

        default: begin // ST_DONE
          if (substateRx != entry_sub) begin
            state      <= ST_IDLE;
            finish_reg <= 1'b0;
            goto_reg   <= SUB_DETECT_QUIET;
            ts_count   <= 4'd0;
            timer      <= '0;
          end
        end
      endcase
    end
  end

  assign finishRx   = finish_reg;
  assign gotoRx     = goto_reg;
  assign tsCount    = ts_count;
  assign timeoutHit = timeout_reg;

endmodule
